serial_subtractor_ctrl: RTL and testbench

Bit-serial N-bit subtractor built around a single 1-bit full-subtractor cell. The controller latches two operands and an initial borrow. It then steps the cell once per clock, LSB first, feeding each borrow-out back into the next bit, and presents the N-bit difference and final borrow with a start/done handshake. It trades N cycles of latency for one subtractor cell, and sits between a register-level requester and the team's gate-level subtractor cell.

---
 rtl/serial_subtractor_ctrl_pkg.sv | 14 +
 rtl/serial_subtractor_ctrl_fullsub_bit.sv | 18 +
 rtl/serial_subtractor_ctrl.sv | 142 ++++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_ctrl_pkg.sv
// serial_sub_pkg: shared definitions for the bit-serial subtractor controller.
//   sub_state_e   : controller FSM states (IDLE, SHIFT, DONE)
//   SUB_WIDTH_DEF : default operand/result width
package serial_sub_pkg;

    localparam int unsigned SUB_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } sub_state_e;

endpackage

// File: rtl/serial_subtractor_ctrl_fullsub_bit.sv
// fullsub_bit: purely combinational 1-bit full subtractor (a - b - bin).
//   diff : difference bit
//   bout : borrow out
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
module fullsub_bit (
    output logic diff,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial WIDTH-bit subtractor using one fullsub_bit
// cell, LSB first, one bit per clock, start/done handshake.
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start           : request, accepted in IDLE or DONE
//   a, b, bin       : minuend, subtrahend, initial borrow (latched on accept)
//   busy            : high while bits are being processed
//   done            : one-cycle pulse, result valid
//   diff, bout      : registered a - b - bin (mod 2^WIDTH) and final borrow
//   ovf             : signed overflow, only when SERIAL_SUB_OVF_EN is defined
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned         CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]    LAST   = CNT_W'(WIDTH - 1);
`ifdef SERIAL_SUB_OVF_EN
    localparam logic [CNT_W-1:0]    PENULT = CNT_W'(WIDTH - 2);
`endif

    sub_state_e        state, state_nxt;
    logic              load, step, last;

    logic [WIDTH-1:0]  a_sh, b_sh;
    // The final diff bit goes straight into diff, so only WIDTH-1 bits are kept.
    logic [WIDTH-2:0]  d_sh;
    logic [WIDTH-1:0]  d_nxt;
    logic              brw;
    logic [CNT_W-1:0]  cnt;
    logic              cell_d, cell_bo;
`ifdef SERIAL_SUB_OVF_EN
    logic              brw_msb;
`endif

    fullsub_bit u_cell (
        .diff (cell_d),
        .bout (cell_bo),
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw)
    );

    assign d_nxt = {cell_d, d_sh};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = (cnt == LAST);
        unique case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers are written on the last SHIFT edge so they are already
    // valid during the DONE cycle, together with the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            d_sh <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            brw_msb <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            busy <= (state_nxt == SHIFT);
            done <= 1'b0;
            if (load) begin
                a_sh <= a;
                b_sh <= b;
                brw  <= bin;
                cnt  <= '0;
            end
            if (step) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                d_sh <= d_nxt[WIDTH-1:1];
                brw  <= cell_bo;
                cnt  <= cnt + CNT_W'(1);
`ifdef SERIAL_SUB_OVF_EN
                // Borrow out of bit WIDTH-2 is the borrow into the MSB.
                if (cnt == PENULT) brw_msb <= cell_bo;
`endif
                if (last) begin
                    diff <= d_nxt;
                    bout <= cell_bo;
                    done <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    ovf  <= brw_msb ^ cell_bo;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
module tb_serial_subtractor_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done, bout;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int unsigned  due;
    } exp_t;

    exp_t         q[$];
    int unsigned  checks   = 0;
    int unsigned  failures = 0;
    logic         mon_en   = 1'b0;
    logic [W-1:0] hold_d   = '0;
    logic         hold_bo  = 1'b0;
    logic         hold_ov  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mbin, input int unsigned due);
        exp_t e;
        int   r, sr;
        r    = int'(ma) - int'(mb) - int'(mbin);
        sr   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        e.d  = W'(r);
        e.bo = (r < 0);
        e.ov = (sr < -(2 ** (W - 1))) || (sr > (2 ** (W - 1)) - 1);
        e.due = due;
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever done is seen.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_busy;
            exp_busy = 1'b0;
            foreach (q[i]) if (cyc + 8 >= q[i].due && cyc < q[i].due) exp_busy = 1'b1;
            check("busy", 32'(busy), 32'(exp_busy));
            if (q.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else if (done) begin
                exp_t e;
                e = q.pop_front();
                check("done_cycle", cyc, e.due);
                check("diff", 32'(diff), 32'(e.d));
                check("bout", 32'(bout), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ov));
`endif
                hold_d  = e.d;
                hold_bo = e.bo;
                hold_ov = e.ov;
            end else if (cyc >= q[0].due) begin
                check("done_latency", 32'(done), 32'd1);
                void'(q.pop_front());
            end
            check("diff_hold", 32'(diff), 32'(hold_d));
            check("bout_hold", 32'(bout), 32'(hold_bo));
`ifdef SERIAL_SUB_OVF_EN
            check("ovf_hold", 32'(ovf), 32'(hold_ov));
`endif
        end
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        q.push_back(model(ta, tb, tbin, cyc + 9));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            check("idle_timeout", q.size(), 32'd0);
            q.delete();
        end
    endtask

    task automatic b2b(input logic [W-1:0] a1, input logic [W-1:0] b1, input logic bin1,
                       input logic [W-1:0] a2, input logic [W-1:0] b2, input logic bin2);
        int unsigned s;
        s = cyc;
        a = a1; b = b1; bin = bin1; start = 1'b1;
        q.push_back(model(a1, b1, bin1, s + 9));
        @(posedge clk); #1;
        a = a2; b = b2; bin = bin2;
        while (cyc < s + 9) begin
            @(posedge clk); #1;
        end
        q.push_back(model(a2, b2, bin2, cyc + 9));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", 32'(ovf), 32'd0);
`endif
        mon_en = 1'b1;
        @(posedge clk); #1;

        issue(8'h5A, 8'h23, 1'b0); wait_idle();
        issue(8'h00, 8'h01, 1'b0); wait_idle();
        issue(8'h10, 8'h10, 1'b1); wait_idle();
        issue(8'h80, 8'h01, 1'b0); wait_idle();
        issue(8'h7F, 8'hFF, 1'b0); wait_idle();
        issue(8'h05, 8'h03, 1'b0); wait_idle();

        // Start pulse while busy must be ignored.
        issue(8'h09, 8'h04, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        b2b(8'h44, 8'h22, 1'b0, 8'h33, 8'h11, 1'b0);
        wait_idle();

        // Reset in SHIFT cycle 4 aborts the operation.
        issue(8'h12, 8'h34, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        hold_d = '0; hold_bo = 1'b0; hold_ov = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        @(posedge clk); #1;
        issue(8'h80, 8'h01, 1'b0); wait_idle();

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            issue(W'($urandom), W'($urandom), 1'($urandom));
            wait_idle();
        end
        for (int i = 0; i < 5; i++) begin
            b2b(W'($urandom), W'($urandom), 1'($urandom),
                W'($urandom), W'($urandom), 1'($urandom));
            wait_idle();
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
